// File: rtl/intersection_ctrl.sv
// Two-way intersection sequencer: one FSM drives both lamp sets, so both directions can never be non-red at once.
// Green time follows synchronized request flags, bounded by minimum and maximum greens, yellow and all-red intervals.
module intersection_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALL_RED_T = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req1_i,
    input  logic req2_i,
    output logic red1_o,
    output logic yellow1_o,
    output logic green1_o,
    output logic red2_o,
    output logic yellow2_o,
    output logic green2_o,
    output logic busy1_o,
    output logic busy2_o
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned T_MAX0 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int unsigned T_MAX  = (T_MAX0 > ALL_RED_T) ? T_MAX0 : ALL_RED_T;
    localparam int unsigned T_W    = $clog2(T_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [T_W:0]      GMIN_N    = (T_W + 1)'(GREEN_MIN);
    localparam logic [T_W:0]      GMAX_N    = (T_W + 1)'(GREEN_MAX);
    localparam logic [T_W:0]      YEL_N     = (T_W + 1)'(YELLOW_T);
    localparam logic [T_W:0]      AR_N      = (T_W + 1)'(ALL_RED_T);

    typedef enum logic [2:0] {
        ST_ALLRED2 = 3'd0,
        ST_GREEN1  = 3'd1,
        ST_YELLOW1 = 3'd2,
        ST_ALLRED1 = 3'd3,
        ST_GREEN2  = 3'd4,
        ST_YELLOW2 = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [T_W-1:0]    t_q, t_d;
    logic              pending1_q, pending1_d;
    logic              pending2_q, pending2_d;
    logic              req1_meta_q, req1_meta_d, req1_sync_q, req1_sync_d;
    logic              req2_meta_q, req2_meta_d, req2_sync_q, req2_sync_d;

    logic              tick;
    logic              changed;
    logic [T_W:0]      n;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_ALLRED2;
            tick_cnt_q  <= '0;
            t_q         <= '0;
            pending1_q  <= 1'b0;
            pending2_q  <= 1'b0;
            req1_meta_q <= 1'b0;
            req1_sync_q <= 1'b0;
            req2_meta_q <= 1'b0;
            req2_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            t_q         <= t_d;
            pending1_q  <= pending1_d;
            pending2_q  <= pending2_d;
            req1_meta_q <= req1_meta_d;
            req1_sync_q <= req1_sync_d;
            req2_meta_q <= req2_meta_d;
            req2_sync_q <= req2_sync_d;
        end
    end

    always_comb begin
        req1_meta_d = req1_i;
        req1_sync_d = req1_meta_q;
        req2_meta_d = req2_i;
        req2_sync_d = req2_meta_q;

        tick    = (tick_cnt_q == TICK_LAST);
        n       = {1'b0, t_q} + 1'b1;
        state_d = state_q;

        case (state_q)
            ST_ALLRED2: if (tick && n == AR_N) state_d = ST_GREEN1;
            ST_GREEN1:  if (tick && ((n >= GMIN_N && pending2_q) || n == GMAX_N)) state_d = ST_YELLOW1;
            ST_YELLOW1: if (tick && n == YEL_N) state_d = ST_ALLRED1;
            ST_ALLRED1: if (tick && n == AR_N) state_d = ST_GREEN2;
            ST_GREEN2:  if (tick && ((n >= GMIN_N && pending1_q) || n == GMAX_N)) state_d = ST_YELLOW2;
            ST_YELLOW2: if (tick && n == YEL_N) state_d = ST_ALLRED2;
            default:    state_d = ST_ALLRED2;
        endcase

        // Any state change (including recovery from an illegal code) restarts both timers.
        changed    = (state_d != state_q);
        tick_cnt_d = (changed || tick) ? '0 : tick_cnt_q + 1'b1;
        if (changed)   t_d = '0;
        else if (tick) t_d = n[T_W-1:0];
        else           t_d = t_q;

        pending1_d = pending1_q | (req1_sync_q && state_q != ST_GREEN1);
        pending2_d = pending2_q | (req2_sync_q && state_q != ST_GREEN2);
        if (state_d == ST_GREEN1 && state_q != ST_GREEN1) pending1_d = 1'b0;
        if (state_d == ST_GREEN2 && state_q != ST_GREEN2) pending2_d = 1'b0;
    end

    always_comb begin
        red1_o    = 1'b1;
        yellow1_o = 1'b0;
        green1_o  = 1'b0;
        red2_o    = 1'b1;
        yellow2_o = 1'b0;
        green2_o  = 1'b0;
        case (state_q)
            ST_GREEN1:  begin red1_o = 1'b0; green1_o  = 1'b1; end
            ST_YELLOW1: begin red1_o = 1'b0; yellow1_o = 1'b1; end
            ST_GREEN2:  begin red2_o = 1'b0; green2_o  = 1'b1; end
            ST_YELLOW2: begin red2_o = 1'b0; yellow2_o = 1'b1; end
            default:    ;
        endcase
    end

    assign busy1_o = pending1_q;
    assign busy2_o = pending2_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed and random checks of intersection_ctrl with short timing parameters (4-cycle tick).
module tb_intersection_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, req1, req2;
    logic red1, yellow1, green1, red2, yellow2, green2, busy1, busy2;

    intersection_ctrl #(
        .TICK_DIV (4),
        .GREEN_MIN(3),
        .GREEN_MAX(8),
        .YELLOW_T (2),
        .ALL_RED_T(1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .req1_i   (req1),
        .req2_i   (req2),
        .red1_o   (red1),
        .yellow1_o(yellow1),
        .green1_o (green1),
        .red2_o   (red2),
        .yellow2_o(yellow2),
        .green2_o (green2),
        .busy1_o  (busy1),
        .busy2_o  (busy2)
    );

    // Lamp vector {red1, yellow1, green1, red2, yellow2, green2}
    logic [5:0] lamps;
    assign lamps = {red1, yellow1, green1, red2, yellow2, green2};

    localparam logic [5:0] AR = 6'b100_100;
    localparam logic [5:0] G1 = 6'b001_100;
    localparam logic [5:0] Y1 = 6'b010_100;
    localparam logic [5:0] G2 = 6'b100_001;
    localparam logic [5:0] Y2 = 6'b100_010;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive samples showing the given lamp pattern (bounded).
    task automatic measure(input logic [5:0] pat, output int len);
        len = 0;
        while (lamps === pat && len < 200) begin
            len++;
            step();
        end
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        req1  = 1'b0;
        req2  = 1'b0;
        repeat (3) step();
        check_eq("rst_lamps", int'(lamps), int'(AR));
        check_eq("rst_busy", int'({busy1, busy2}), 0);
        rst_n = 1'b1;
    endtask

    int n;
    int viol_one, viol_excl, w1, w2, max_wait, served1, served2;

    initial begin
        rst_n = 1'b0;
        req1  = 1'b0;
        req2  = 1'b0;

        // No requests: full-length cycle, 88-cycle period
        reset_seq();
        measure(AR, n); check_eq("s1_allred_start", n, 4);
        measure(G1, n); check_eq("s1_green1", n, 32);
        measure(Y1, n); check_eq("s1_yellow1", n, 8);
        measure(AR, n); check_eq("s1_allred1", n, 4);
        measure(G2, n); check_eq("s1_green2", n, 32);
        measure(Y2, n); check_eq("s1_yellow2", n, 8);
        measure(AR, n); check_eq("s1_allred2", n, 4);
        measure(G1, n); check_eq("s1_green1_again", n, 32);

        // req2 held from reset release: minimum green
        reset_seq();
        req2 = 1'b1;
        measure(AR, n); check_eq("s2_allred_start", n, 4);
        measure(G1, n); check_eq("s2_green1_min", n, 12);
        check_eq("s2_busy2_set", int'(busy2), 1);
        measure(Y1, n); check_eq("s2_yellow1", n, 8);
        measure(AR, n); check_eq("s2_allred1", n, 4);
        check_eq("s2_green2_entry", int'(lamps), int'(G2));
        check_eq("s2_busy2_clr", int'(busy2), 0);
        req2 = 1'b0;

        // 1-cycle req2 pulse 24 cycles into green1
        reset_seq();
        measure(AR, n);
        repeat (24) step();
        req2 = 1'b1;
        step();
        req2 = 1'b0;
        check_eq("s3_busy2_early", int'(busy2), 0);
        step();
        step();
        check_eq("s3_busy2_rise", int'(busy2), 1);
        measure(G1, n); check_eq("s3_green1_len", 27 + n, 28);

        // req1 during own green is ignored
        reset_seq();
        measure(AR, n);
        req1 = 1'b1;
        repeat (10) step();
        req1 = 1'b0;
        check_eq("s4_busy1_in_green", int'(busy1), 0);
        measure(G1, n); check_eq("s4_green1_full", 10 + n, 32);
        check_eq("s4_busy1_after", int'(busy1), 0);

        // Asynchronous reset in the middle of yellow2
        measure(Y1, n); check_eq("s5_yellow1", n, 8);
        measure(AR, n); check_eq("s5_allred1", n, 4);
        measure(G2, n); check_eq("s5_green2_full", n, 32);
        req1 = 1'b1;
        repeat (3) step();
        check_eq("s5_in_yellow2", int'(lamps), int'(Y2));
        check_eq("s5_busy1_set", int'(busy1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s5_async_lamps", int'(lamps), int'(AR));
        check_eq("s5_async_busy", int'({busy1, busy2}), 0);
        req1 = 1'b0;
        step();
        rst_n = 1'b1;
        measure(AR, n); check_eq("s5_restart_allred", n, 4);
        measure(G1, n); check_eq("s5_restart_green1", n, 32);

        // Random requests: safety invariants and bounded waiting
        reset_seq();
        viol_one = 0; viol_excl = 0; max_wait = 0;
        w1 = -1; w2 = -1; served1 = 0; served2 = 0;
        for (int c = 0; c < 10000; c++) begin
            if ((int'(red1) + int'(yellow1) + int'(green1)) != 1 ||
                (int'(red2) + int'(yellow2) + int'(green2)) != 1)
                viol_one++;
            if (!red1 && !red2) viol_excl++;
            if (green1) begin
                if (w1 >= 0) begin
                    served1++;
                    if (w1 > max_wait) max_wait = w1;
                end
                w1 = -1;
            end else if (w1 >= 0) w1++;
            else if (req1) w1 = 0;
            if (green2) begin
                if (w2 >= 0) begin
                    served2++;
                    if (w2 > max_wait) max_wait = w2;
                end
                w2 = -1;
            end else if (w2 >= 0) w2++;
            else if (req2) w2 = 0;
            if (w1 > max_wait) max_wait = w1;
            if (w2 > max_wait) max_wait = w2;
            if ($urandom_range(0, 7) == 0) req1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) req2 = 1'($urandom_range(0, 1));
            step();
        end
        $display("info random max_wait=%0d served1=%0d served2=%0d", max_wait, served1, served2);
        check_eq("s6_one_lamp_viol", viol_one, 0);
        check_eq("s6_exclusive_viol", viol_excl, 0);
        check_eq("s6_wait_le_44", (max_wait <= 44) ? 1 : 0, 1);
        check_eq("s6_served1", (served1 > 0) ? 1 : 0, 1);
        check_eq("s6_served2", (served2 > 0) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
- Request-driven sequencer for a two-way intersection. Drives two red/yellow/green lamp sets from one state machine, so the two directions can never both be non-red.
- Allocates green time between directions from latched switch requests, with minimum, maximum, yellow and all-red intervals.
- Instantiated at the practice top level, between the board switches/clock and the lamp outputs.

Parameters:
- TICK_DIV, 50_000_000: clk_i cycles per timing tick (1 s at 50 MHz).
- GREEN_MIN, 5: minimum green duration, in ticks.
- GREEN_MAX, 20: maximum green duration, in ticks.
- YELLOW_T, 3: yellow duration, in ticks.
- ALL_RED_T, 1: all-red clearance duration, in ticks.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-low reset
- req1_i  input  1  direction-1 green request (raw switch, asynchronous level)
- req2_i  input  1  direction-2 green request (raw switch, asynchronous level)
- red1_o  output  1  direction-1 red lamp
- yellow1_o  output  1  direction-1 yellow lamp
- green1_o  output  1  direction-1 green lamp
- red2_o  output  1  direction-2 red lamp
- yellow2_o  output  1  direction-2 yellow lamp
- green2_o  output  1  direction-2 green lamp
- busy1_o  output  1  direction-1 request pending
- busy2_o  output  1  direction-2 request pending

Behaviour:
- Reset: one clock, clk_i. rst_i is asynchronous and active-low. While rst_i=0:
  - state = ALLRED2, tick counter = 0, state timer = 0, pendings = 0, synchronizers = 0.
  - Outputs: red1_o=red2_o=1, all other outputs 0.
  - Reset asserted mid-sequence forces this condition immediately, without waiting for a clock edge.
- Input sync: each req passes through a 2-FF synchronizer, giving 2 cycles of latency.
- Pending flags:
  - pendingK sets on any cycle the synchronized reqK=1 while direction K is not GREEN.
  - pendingK clears on the edge that enters GREEN_K; the clear wins over a simultaneous set.
  - A request made during the direction's own green is ignored.
  - busyK_o = pendingK.
- Tick generator:
  - Counts 0..TICK_DIV-1 and asserts tick when the count = TICK_DIV-1.
  - Restarts at 0 on every state transition, so every state lasts an exact multiple of TICK_DIV cycles.
- State timer t: counts ticks since state entry; resets to 0 on each transition.
- States and lamps (Moore, decoded from the state register, no combinational path from inputs):
  - GREEN1: green1, red2.
  - YELLOW1: yellow1, red2.
  - ALLRED1: red1, red2.
  - GREEN2: red1, green2.
  - YELLOW2: red1, yellow2.
  - ALLRED2: red1, red2.
- Transitions, evaluated only on a tick cycle, with n = t+1:
  - ALLRED2 -> GREEN1 when n = ALL_RED_T.
  - GREEN1 -> YELLOW1 when (n >= GREEN_MIN and pending2=1) or n = GREEN_MAX.
  - YELLOW1 -> ALLRED1 when n = YELLOW_T.
  - ALLRED1 -> GREEN2 when n = ALL_RED_T.
  - GREEN2, YELLOW2 and ALLRED2 mirror GREEN1, YELLOW1 and ALLRED1 with the directions swapped.
- Arbitration: strict alternation with no skipping, so each direction gets green at least every 2*(GREEN_MAX+YELLOW_T+ALL_RED_T) ticks. Simultaneous requests are served in alternation order.
- Invariants:
  - Exactly one lamp per direction is lit on every cycle.
  - green/yellow of direction 1 and green/yellow of direction 2 are never both active.
  - Illegal state encodings recover to ALLRED2 on the next edge.
- Width rules:
  - Tick counter width = clog2(TICK_DIV).
  - Timer width = clog2(max(GREEN_MAX, YELLOW_T, ALL_RED_T)+1).
  - Parameters require 1 <= GREEN_MIN <= GREEN_MAX.

Test Plan:
Bench parameters: TICK_DIV=4, GREEN_MIN=3, GREEN_MAX=8, YELLOW_T=2, ALL_RED_T=1.
- Reset release, no requests -> ALLRED for 4 cycles, then green1 for 32, yellow1 for 8, all-red for 4, then green2. The sequence repeats with period 88 cycles.
- req2_i held high from reset release -> green1 lasts exactly 12 cycles (GREEN_MIN). busy2_o clears on the green2 entry edge.
- 1-cycle req2_i pulse arriving 24 cycles into green1 -> busy2_o rises 2–3 cycles later; yellow1 starts at the next tick boundary, i.e. green1 lasts 28 cycles.
- req1_i asserted during green1 only -> busy1_o stays 0 and green1 runs the full 32 cycles.
- rst_i driven low mid-YELLOW2, asynchronously between edges -> red1_o=red2_o=1 and all other outputs 0 immediately. After release, the startup sequence of the first scenario repeats.
- Random req1/req2 over 10,000 cycles -> no cycle has both directions non-red, exactly one lamp per direction is lit, and no direction waits more than 44 cycles after a request before its green starts.
